// File: rtl/vga_region_scheduler_if.sv
// Bundle between the VGA region scheduler and the game/display side.
//   run               : counting enable from the system (low = hold counters, blank enables)
//   cell_x / cell_y   : game cell requested from the game block (one cycle after the count)
//   hsync / vsync     : active-low sync, two cycles after the count
//   display_area      : pixel inside the visible area
//   game_enable       : pixel inside the game field
//   score_time_enable : pixel inside the score/time bar
//   frame_tick        : one-cycle pulse at the start of vertical blanking
// The scheduler uses the master modport; the consumer uses slave.
interface vga_region_scheduler_if;
    logic       run;
    logic [5:0] cell_x;
    logic [4:0] cell_y;
    logic       hsync;
    logic       vsync;
    logic       display_area;
    logic       game_enable;
    logic       score_time_enable;
    logic       frame_tick;

    modport master (
        input  run,
        output cell_x,
        output cell_y,
        output hsync,
        output vsync,
        output display_area,
        output game_enable,
        output score_time_enable,
        output frame_tick
    );

    modport slave (
        output run,
        input  cell_x,
        input  cell_y,
        input  hsync,
        input  vsync,
        input  display_area,
        input  game_enable,
        input  score_time_enable,
        input  frame_tick
    );
endinterface

// File: rtl/vga_region_scheduler.sv
// VGA raster scheduler: horizontal/vertical pixel counters plus a two-stage
// pipeline. Stage 1 turns the current count into a game cell request
// (cell_x/cell_y); stage 2 presents the sync and region enables so they line up
// with the colour the game block returns one cycle after the cell request.
//
// Ports:
//   clock_25 : pixel clock
//   reset    : synchronous, active-high
//   vga      : vga_region_scheduler_if.master (run in; cell, sync, enables, frame_tick out)
module vga_region_scheduler #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SCORE_H    = 32,
    parameter int unsigned CELL_SHIFT = 4
) (
    input  logic                          clock_25,
    input  logic                          reset,
    vga_region_scheduler_if.master        vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One spare code so the sync end bound still fits when the back porch is zero.
    localparam int unsigned HCW = $clog2(H_TOTAL + 1);
    localparam int unsigned VCW = $clog2(V_TOTAL + 1);

    localparam logic [HCW-1:0] HMax       = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] HActive    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HSyncStart = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HSyncEnd   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] HOne       = HCW'(1);

    localparam logic [VCW-1:0] VMax       = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] VActive    = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VSyncStart = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VSyncEnd   = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] VOne       = VCW'(1);
    localparam logic [VCW-1:0] ScoreH     = VCW'(SCORE_H);

    typedef struct packed {
        logic display;
        logic game;
        logic score;
        logic hsync;
        logic vsync;
        logic tick;
    } flags_t;

    localparam flags_t FlagsRst = '{
        display: 1'b0,
        game:    1'b0,
        score:   1'b0,
        hsync:   1'b1,
        vsync:   1'b1,
        tick:    1'b0
    };

    logic [HCW-1:0] h_q, h_d;
    logic [VCW-1:0] v_q, v_d;
    logic [5:0]     cell_x_q, cell_x_d;
    logic [4:0]     cell_y_q, cell_y_d;
    flags_t         s1_q, s1_d;
    flags_t         s2_q, s2_d;

    logic           in_display;
    logic           in_game;
    logic           in_score;
    logic [VCW-1:0] v_game;

    // Raster counters: advance only while run is high; v steps on the h wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vga.run) begin
            if (h_q == HMax) begin
                h_d = '0;
                if (v_q == VMax) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + VOne;
                end
            end else begin
                h_d = h_q + HOne;
            end
        end
    end

    // Stage 1: region decode of the current count.
    always_comb begin
        in_display = (h_q < HActive) && (v_q < VActive);
        in_game    = in_display && (v_q >= ScoreH);
        in_score   = in_display && (v_q < ScoreH);
        // Only consumed inside the game field, where v_q >= ScoreH, so no wrap.
        v_game     = v_q - ScoreH;

        cell_x_d = '0;
        cell_y_d = '0;
        if (in_game) begin
            cell_x_d = 6'(h_q >> CELL_SHIFT);
            cell_y_d = 5'(v_game >> CELL_SHIFT);
        end

        s1_d         = FlagsRst;
        // Enables and tick are qualified by run; sync follows the held count.
        s1_d.display = vga.run & in_display;
        s1_d.game    = vga.run & in_game;
        s1_d.score   = vga.run & in_score;
        s1_d.hsync   = ~((h_q >= HSyncStart) && (h_q < HSyncEnd));
        s1_d.vsync   = ~((v_q >= VSyncStart) && (v_q < VSyncEnd));
        s1_d.tick    = vga.run & (h_q == '0) & (v_q == VActive);

        // Stage 2: one more cycle to meet the colour returned by the game block.
        s2_d = s1_q;
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            cell_x_q <= '0;
            cell_y_q <= '0;
            s1_q     <= FlagsRst;
            s2_q     <= FlagsRst;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            cell_x_q <= cell_x_d;
            cell_y_q <= cell_y_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign vga.cell_x            = cell_x_q;
    assign vga.cell_y            = cell_y_q;
    assign vga.hsync             = s2_q.hsync;
    assign vga.vsync             = s2_q.vsync;
    assign vga.display_area      = s2_q.display;
    assign vga.game_enable       = s2_q.game;
    assign vga.score_time_enable = s2_q.score;
    assign vga.frame_tick        = s2_q.tick;

endmodule

// File: tb/tb_vga_region_scheduler.sv
// Bench for vga_region_scheduler. Two instances share clock and reset:
//   dut_s : shrunken timing (128 x 50 frame) with randomised run, tracked by a
//           per-count behavioural model;
//   dut_d : default timing with run tied high, checked in closed form from the
//           number of cycles since reset release.
module tb_vga_region_scheduler;

    // Small raster for dut_s.
    localparam int S_HA = 96;
    localparam int S_HFP = 8;
    localparam int S_HS = 12;
    localparam int S_HBP = 12;
    localparam int S_VA = 40;
    localparam int S_VFP = 3;
    localparam int S_VS = 2;
    localparam int S_VBP = 5;
    localparam int S_SH = 8;
    localparam int S_CS = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

    typedef struct packed {
        logic [5:0] cx;
        logic [4:0] cy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ge;
        logic       se;
        logic       ft;
    } exp_t;

    localparam exp_t RST = '{cx: 6'd0, cy: 5'd0, hs: 1'b1, vs: 1'b1,
                             de: 1'b0, ge: 1'b0, se: 1'b0, ft: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run_s = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    vga_region_scheduler_if bus_s ();
    vga_region_scheduler_if bus_d ();

    assign bus_s.run = run_s;
    assign bus_d.run = 1'b1;

    vga_region_scheduler #(
        .H_ACTIVE   (S_HA),
        .H_FP       (S_HFP),
        .H_SYNC     (S_HS),
        .H_BP       (S_HBP),
        .V_ACTIVE   (S_VA),
        .V_FP       (S_VFP),
        .V_SYNC     (S_VS),
        .V_BP       (S_VBP),
        .SCORE_H    (S_SH),
        .CELL_SHIFT (S_CS)
    ) dut_s (
        .clock_25 (clk),
        .reset    (reset),
        .vga      (bus_s)
    );

    vga_region_scheduler dut_d (
        .clock_25 (clk),
        .reset    (reset),
        .vga      (bus_d)
    );

    always #5 clk = ~clk;

    // What a count (h, v) presented with run r must produce, from the region rules.
    function automatic exp_t calc(int h, int v, bit r, int ha, int hfp, int hs, int va,
                                  int vfp, int vs, int sh, int cs);
        exp_t e;
        bit de;
        bit ge;
        de = (h < ha) && (v < va);
        ge = de && (v >= sh);
        e.cx = ge ? 6'(h >> cs) : 6'd0;
        e.cy = ge ? 5'((v - sh) >> cs) : 5'd0;
        e.hs = !((h >= ha + hfp) && (h < ha + hfp + hs));
        e.vs = !((v >= va + vfp) && (v < va + vfp + vs));
        e.de = r && de;
        e.ge = r && ge;
        e.se = r && de && (v < sh);
        e.ft = r && (h == 0) && (v == va);
        return e;
    endfunction

    function automatic exp_t calc_s(int h, int v, bit r);
        return calc(h, v, r, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS, S_SH, S_CS);
    endfunction

    // n-th count after release on the default 800 x 525 raster.
    function automatic exp_t calc_d(int n);
        return calc(n % 800, (n / 800) % 525, 1'b1, 640, 16, 96, 480, 10, 2, 32, 4);
    endfunction

    // Cell fields come from stage 1, everything else from stage 2.
    function automatic exp_t merge(exp_t st1, exp_t st2);
        exp_t e;
        e = st2;
        e.cx = st1.cx;
        e.cy = st1.cy;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model for dut_s: current count plus the last two count outcomes.
    int   mh = 0;
    int   mv = 0;
    exp_t m1 = RST;
    exp_t m2 = RST;
    bit   mvalid = 1'b0;
    int   dk = 0;

    always @(posedge clk) begin
        if (reset) begin
            mh <= 0;
            mv <= 0;
            m1 <= RST;
            m2 <= RST;
            mvalid <= 1'b1;
            dk <= 0;
        end else begin
            m2 <= m1;
            m1 <= calc_s(mh, mv, run_s);
            dk <= dk + 1;
            if (run_s) begin
                if (mh == S_HT - 1) begin
                    mh <= 0;
                    mv <= (mv == S_VT - 1) ? 0 : mv + 1;
                end else begin
                    mh <= mh + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances.
    always @(negedge clk) begin
        exp_t act;
        exp_t want;
        if (mvalid) begin
            act = '{cx: bus_s.cell_x, cy: bus_s.cell_y, hs: bus_s.hsync, vs: bus_s.vsync,
                    de: bus_s.display_area, ge: bus_s.game_enable,
                    se: bus_s.score_time_enable, ft: bus_s.frame_tick};
            chk("stream_s", 32'(act), 32'(merge(m1, m2)));

            act = '{cx: bus_d.cell_x, cy: bus_d.cell_y, hs: bus_d.hsync, vs: bus_d.vsync,
                    de: bus_d.display_area, ge: bus_d.game_enable,
                    se: bus_d.score_time_enable, ft: bus_d.frame_tick};
            want = merge((dk >= 1) ? calc_d(dk - 1) : RST, (dk >= 2) ? calc_d(dk - 2) : RST);
            chk("stream_d", 32'(act), 32'(want));

            // Default raster count (37, 32) is index 25637 after release.
            if (dk == 25638) begin
                chk("d_cell_x_37_32", 32'(bus_d.cell_x), 32'd2);
                chk("d_cell_y_37_32", 32'(bus_d.cell_y), 32'd0);
            end
            if (dk == 25639) begin
                chk("d_game_37_32", 32'(bus_d.game_enable), 32'd1);
            end
        end
    end

    task automatic wait_count(int h, int v, string name);
        int t;
        t = 0;
        while (!(mh == h && mv == v) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(mh == h && mv == v), 32'd1);
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        run_s = 1'b1;
        cyc(3);
        chk("rst_hsync", 32'(bus_s.hsync), 32'd1);
        chk("rst_vsync", 32'(bus_s.vsync), 32'd1);
        chk("rst_display", 32'(bus_s.display_area), 32'd0);
        chk("rst_cell_x", 32'(bus_s.cell_x), 32'd0);
        chk("rst_d_hsync", 32'(bus_d.hsync), 32'd1);

        // Release: display_area rises on the second cycle.
        reset = 1'b0;
        cyc(1);
        chk("rel_display_c1", 32'(bus_s.display_area), 32'd0);
        cyc(1);
        chk("rel_display_c2", 32'(bus_s.display_area), 32'd1);
        chk("rel_score_c2", 32'(bus_s.score_time_enable), 32'd1);
        chk("rel_game_c2", 32'(bus_s.game_enable), 32'd0);
        chk("rel_d_display_c2", 32'(bus_d.display_area), 32'd1);

        // First game line: (37, 8) -> cell (4, 0), then game_enable.
        wait_count(37, 8, "reach_37_8");
        cyc(1);
        chk("cell_x_37_8", 32'(bus_s.cell_x), 32'd4);
        chk("cell_y_37_8", 32'(bus_s.cell_y), 32'd0);
        cyc(1);
        chk("game_37_8", 32'(bus_s.game_enable), 32'd1);
        chk("score_37_8", 32'(bus_s.score_time_enable), 32'd0);

        // Last visible pixel: (95, 39) -> cell (11, 3).
        wait_count(95, 39, "reach_95_39");
        cyc(1);
        chk("cell_x_95_39", 32'(bus_s.cell_x), 32'd11);
        chk("cell_y_95_39", 32'(bus_s.cell_y), 32'd3);

        // Frame period and sync widths with run held high.
        t = 0;
        while (!bus_s.frame_tick && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk("tick_found", 32'(bus_s.frame_tick), 32'd1);
        @(negedge clk);
        t = 1;
        while (!bus_s.frame_tick && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_period", 32'(t), 32'(S_HT * S_VT));

        t = 0;
        while (bus_s.hsync && t < 200) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!bus_s.hsync && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("hsync_low_len", 32'(t), 32'(S_HS));

        t = 0;
        while (bus_s.vsync && t < 8000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!bus_s.vsync && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk("vsync_low_len", 32'(t), 32'(S_VS * S_HT));

        // Drop run for 10 cycles at (55, 20).
        wait_count(55, 20, "reach_55_20");
        run_s = 1'b0;
        cyc(2);
        chk("hold_display_off", 32'(bus_s.display_area), 32'd0);
        chk("hold_cell_x", 32'(bus_s.cell_x), 32'd6);
        cyc(8);
        run_s = 1'b1;
        cyc(1);
        chk("resume_display_c1", 32'(bus_s.display_area), 32'd0);
        cyc(1);
        chk("resume_cell_x_56", 32'(bus_s.cell_x), 32'd7);
        chk("resume_display_c2", 32'(bus_s.display_area), 32'd1);

        // Reset mid-line inside hsync, with run low.
        wait_count(110, 30, "reach_110_30");
        reset = 1'b1;
        run_s = 1'b0;
        cyc(1);
        chk("midrst_hsync", 32'(bus_s.hsync), 32'd1);
        chk("midrst_display", 32'(bus_s.display_area), 32'd0);
        chk("midrst_cell_y", 32'(bus_s.cell_y), 32'd0);
        reset = 1'b0;
        run_s = 1'b1;
        cyc(2);
        chk("midrst_restart_display", 32'(bus_s.display_area), 32'd1);
        chk("midrst_restart_score", 32'(bus_s.score_time_enable), 32'd1);

        // Corner wrap (127, 49) -> (0, 0) without a frame tick.
        wait_count(S_HT - 1, S_VT - 1, "reach_corner");
        cyc(2);
        chk("corner_no_tick", 32'(bus_s.frame_tick), 32'd0);
        cyc(1);
        chk("wrap_display", 32'(bus_s.display_area), 32'd1);
        chk("wrap_no_tick", 32'(bus_s.frame_tick), 32'd0);

        // Random run pattern; the model checks every cycle.
        for (int i = 0; i < 27000; i++) begin
            run_s = ($urandom_range(0, 7) != 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
